// File: rtl/dcb277_alu.sv
// 4-bit signed ALU tile: Z/N/C/V flags on the upper bidirectional pins and a
// sign-magnitude seven-segment display of the result. Purely combinational.
module dcb277_alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_AND  = 4'b0100;
  localparam logic [3:0] FN_OR   = 4'b0101;
  localparam logic [3:0] FN_XOR  = 4'b0110;
  localparam logic [3:0] FN_SLL  = 4'b1000;
  localparam logic [3:0] FN_SRL  = 4'b1001;
  localparam logic [3:0] FN_SRA  = 4'b1010;
  localparam logic [3:0] FN_PASS = 4'b1111;

  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] func;

  logic [4:0]        sum_add;
  logic [4:0]        sum_sub;
  logic [7:0]        sll_ext;
  logic [7:0]        srl_ext;
  logic signed [7:0] sra_ext;

  logic [3:0] res_y;
  logic       flag_z;
  logic       flag_n;
  logic       flag_c;
  logic       flag_v;
  logic [3:0] mag;
  logic [6:0] seg;

  // Clock, enable and the upper func nibble have no role in this tile.
  logic unused_inputs;
  assign unused_inputs = ^{clk, ena, uio_in[7:4]};

  assign op_a = ui_in[3:0];
  assign op_b = ui_in[7:4];
  assign func = uio_in[3:0];

  assign sum_add = {1'b0, op_a} + {1'b0, op_b};
  assign sum_sub = {1'b0, op_a} + {1'b0, ~op_b} + 5'd1;

  // Shifts run in an 8-bit window so the bit just past the result nibble is
  // the last bit shifted out; large amounts fall off the window naturally.
  assign sll_ext = {4'b0000, op_a} << op_b;
  assign srl_ext = {op_a, 4'b0000} >> op_b;
  assign sra_ext = $signed({op_a, 4'b0000}) >>> op_b;

  always_comb begin
    res_y  = 4'd0;
    flag_c = 1'b0;
    flag_v = 1'b0;
    case (func)
      FN_ADD: begin
        res_y  = sum_add[3:0];
        flag_c = sum_add[4];
        flag_v = (op_a[3] == op_b[3]) && (sum_add[3] != op_a[3]);
      end
      FN_SUB: begin
        res_y  = sum_sub[3:0];
        flag_c = sum_sub[4];
        flag_v = (op_a[3] != op_b[3]) && (sum_sub[3] != op_a[3]);
      end
      FN_AND:  res_y = op_a & op_b;
      FN_OR:   res_y = op_a | op_b;
      FN_XOR:  res_y = op_a ^ op_b;
      FN_SLL: begin
        res_y  = sll_ext[3:0];
        flag_c = sll_ext[4];
      end
      FN_SRL: begin
        res_y  = srl_ext[7:4];
        flag_c = srl_ext[3];
      end
      FN_SRA: begin
        res_y  = sra_ext[7:4];
        flag_c = sra_ext[3];
      end
      FN_PASS: res_y = op_a;
      default: begin
        res_y  = 4'd0;
        flag_c = 1'b0;
        flag_v = 1'b0;
      end
    endcase
  end

  assign flag_z = (res_y == 4'd0);
  assign flag_n = res_y[3];

  // -8 negates to 4'b1000, which reads correctly as unsigned 8.
  assign mag = flag_n ? (~res_y + 4'd1) : res_y;

  always_comb begin
    seg = 7'h00;
    case (mag)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      default: seg = 7'h00;
    endcase
  end

  assign uo_out  = rst_n ? {flag_n, seg} : 8'h00;
  assign uio_out = rst_n ? {flag_z, flag_n, flag_c, flag_v, 4'b0000} : 8'h00;
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_dcb277_alu.sv
// Self-checking bench for dcb277_alu: directed test-plan vectors, async reset
// behaviour and randomized operands against an integer-arithmetic model.
module tb_dcb277_alu;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  dcb277_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {uo_out, uio_out} from plain integer arithmetic.
  function automatic int model(input int ua, input int ub, input int f);
    int seg_tab[9] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F};
    int sa, sb, r, y, c, v, z, n, mg;
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    y = 0; c = 0; v = 0;
    case (f)
      0: begin
        r = ua + ub; y = r % 16; c = r / 16;
        v = ((sa + sb) > 7 || (sa + sb) < -8) ? 1 : 0;
      end
      1: begin
        r = ua + (15 - ub) + 1; y = r % 16; c = r / 16;
        v = ((sa - sb) > 7 || (sa - sb) < -8) ? 1 : 0;
      end
      4: y = ua & ub;
      5: y = ua | ub;
      6: y = ua ^ ub;
      8: begin
        r = ua << ub; y = r % 16; c = (r >> 4) & 1;
      end
      9: begin
        y = (ub >= 4) ? 0 : (ua >> ub);
        c = (ub == 0) ? 0 : ((ua >> (ub - 1)) & 1);
      end
      10: begin
        y = (sa >>> ub) & 15;
        c = (ub == 0) ? 0 : ((sa >>> (ub - 1)) & 1);
      end
      15: y = ua;
      default: y = 0;
    endcase
    z  = (y == 0) ? 1 : 0;
    n  = (y >= 8) ? 1 : 0;
    mg = n ? 16 - y : y;
    return ((n * 128 + seg_tab[mg]) << 8) | (z * 128 + n * 64 + c * 32 + v * 16);
  endfunction

  task automatic apply(input int a, input int b, input int f);
    @(negedge clk);
    ui_in  = 8'((b << 4) | a);
    uio_in = 8'(($urandom_range(0, 15) << 4) | f);
    #2;
  endtask

  task automatic check_model(input string tag, input int a, input int b, input int f);
    int exp;
    apply(a, b, f);
    exp = model(a, b, f);
    chk({tag, " uo_out"}, int'(uo_out), (exp >> 8) & 'hFF);
    chk({tag, " uio_out"}, int'(uio_out), exp & 'hFF);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'hA7;
    uio_in = 8'h00;
    #3;
    chk("reset uo_out", int'(uo_out), 'h00);
    chk("reset uio_out", int'(uio_out), 'h00);
    chk("reset uio_oe", int'(uio_oe), 'hF0);

    // Release and undefined func 0011 gives Y = 0.
    rst_n = 1'b1;
    apply(5, 9, 3);
    chk("undef uo_out", int'(uo_out), 'h3F);
    chk("undef uio_out", int'(uio_out), 'h80);

    // Test-plan vectors with hand-derived constants.
    apply(7, 4, 0);
    chk("add ovf uo_out", int'(uo_out), 'hED);
    chk("add ovf flags", int'(uio_out), 'h50);
    apply(3, 3, 1);
    chk("sub zero uo_out", int'(uo_out), 'h3F);
    chk("sub zero flags", int'(uio_out), 'hA0);
    apply(8, 1, 1);
    chk("sub negovf uo_out", int'(uo_out), 'h07);
    chk("sub negovf flags", int'(uio_out), 'h30);
    apply(6, 3, 4);
    chk("and uo_out", int'(uo_out), 'h5B);
    chk("and flags", int'(uio_out), 'h00);
    apply(6, 3, 6);
    chk("xor uo_out", int'(uo_out), 'h6D);
    apply(8, 1, 10);
    chk("sra uo_out", int'(uo_out), 'hE6);
    chk("sra flags", int'(uio_out), 'h40);
    apply(5, 1, 8);
    chk("sll uo_out", int'(uo_out), 'hFD);
    chk("sll flags", int'(uio_out), 'h40);
    apply(5, 1, 9);
    chk("srl uo_out", int'(uo_out), 'h5B);
    chk("srl flags", int'(uio_out), 'h20);

    // Shift boundaries: amount 0, 4 and beyond, plus PASS of -8.
    check_model("sll amt0", 9, 0, 8);
    check_model("sll amt4", 9, 4, 8);
    check_model("srl amt4", 9, 4, 9);
    check_model("sra amt4", 9, 4, 10);
    check_model("sra amt15", 13, 15, 10);
    check_model("srl amt5", 15, 5, 9);
    check_model("pass -8", 8, 2, 15);

    // Asynchronous reset mid-cycle, then immediate recovery.
    apply(7, 4, 0);
    rst_n = 1'b0;
    #1;
    chk("async rst uo_out", int'(uo_out), 'h00);
    chk("async rst uio_out", int'(uio_out), 'h00);
    chk("async rst uio_oe", int'(uio_oe), 'hF0);
    rst_n = 1'b1;
    #1;
    chk("release uo_out", int'(uo_out), 'hED);

    for (int i = 0; i < 400; i++) begin
      int fa, fb, ff;
      fa = $urandom_range(0, 15);
      fb = $urandom_range(0, 15);
      ff = (i % 4 == 0) ? $urandom_range(0, 15) : int'(($urandom_range(0, 8) == 8) ? 15 :
           (($urandom_range(0, 1) == 0) ? $urandom_range(0, 1) : $urandom_range(4, 10)));
      check_model("rand", fa, fb, ff);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
